// File: rtl/multicycle_datapath_if.sv
// Unified memory port for the multicycle core: one request at a time,
// completed by mem_ready, with unbounded wait states.
interface multicycle_datapath_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle RV32 subset core (lw, sw, R/I ALU ops, beq, jal) sharing a single
// memory port between instruction fetch and data access.
//
// state  | meaning
// FETCH  | request word at pc; on ready latch IR/old_pc, pc += 4
// DECODE | latch rs1/rs2 values, dispatch on opcode, handle illegal encodings
// MEMADR | effective address = rs1 + imm (word aligned)
// MEMRD  | load request; on ready latch read data
// MEMWB  | write loaded data to rd, retire
// MEMWR  | store request; on ready retire
// EXECR  | register-register ALU op into alu_out
// EXECI  | register-immediate ALU op into alu_out
// ALUWB  | write alu_out to rd, retire
// BEQ    | branch resolve, retire
// JAL    | link value into alu_out, pc = old_pc + imm_j
// TRAP   | halted on illegal instruction until reset
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_datapath_if.master mem,
  output logic [31:0]           pc,
  output logic                  retire,
  output logic                  trap
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] mdr_q, mdr_d;
  logic        boot_q, boot_d;

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic        mem_req_w, mem_we_w, retire_w, trap_w, xfer;
  logic [31:0] mem_addr_w;

  // instruction fields
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic        alu_f3_ok, is_lw, is_sw, is_r, is_i, is_beq, is_jal, illegal;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] alu_b, alu_res;

  always_comb begin
    opcode = ir_q[6:0];
    rd     = ir_q[11:7];
    funct3 = ir_q[14:12];
    rs1    = ir_q[19:15];
    rs2    = ir_q[24:20];
    funct7 = ir_q[31:25];
    imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                (funct3 == 3'b100) || (funct3 == 3'b010);
    is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_r    = (opcode == 7'b0110011) &&
              (((funct7 == 7'b0000000) && alu_f3_ok) ||
               ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    is_i    = (opcode == 7'b0010011) && alu_f3_ok;
    is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
    is_jal  = (opcode == 7'b1101111);
    illegal = !(is_lw || is_sw || is_r || is_i || is_beq || is_jal);
  end

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  always_comb begin
    alu_b   = (state_q == S_EXECR) ? b_q : imm_i;
    alu_res = 32'd0;
    case (funct3)
      3'b000: alu_res = ((state_q == S_EXECR) && funct7[5]) ? (a_q - alu_b) : (a_q + alu_b);
      3'b111: alu_res = a_q & alu_b;
      3'b110: alu_res = a_q | alu_b;
      3'b100: alu_res = a_q ^ alu_b;
      3'b010: alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
      default: alu_res = 32'd0;
    endcase
  end

  assign xfer = mem_req_w && mem.mem_ready;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (xfer) state_d = S_DECODE;
      S_DECODE: begin
        if (is_lw || is_sw)       state_d = S_MEMADR;
        else if (is_r)            state_d = S_EXECR;
        else if (is_i)            state_d = S_EXECI;
        else if (is_beq)          state_d = S_BEQ;
        else if (is_jal)          state_d = S_JAL;
        else if (TRAP_ON_ILLEGAL) state_d = S_TRAP;
        else                      state_d = S_FETCH;
      end
      S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (xfer) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (xfer) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // outputs; boot_q keeps the port idle for the first cycle out of reset
  always_comb begin
    mem_req_w  = 1'b0;
    mem_we_w   = 1'b0;
    mem_addr_w = addr_q;
    retire_w   = 1'b0;
    trap_w     = 1'b0;
    rf_we      = 1'b0;
    rf_wdata   = alu_q;
    case (state_q)
      S_FETCH: begin
        mem_req_w  = !boot_q;
        mem_addr_w = pc_q & 32'hFFFF_FFFC;
      end
      S_DECODE: retire_w = illegal && !TRAP_ON_ILLEGAL;
      S_MEMRD:  mem_req_w = 1'b1;
      S_MEMWR: begin
        mem_req_w = 1'b1;
        mem_we_w  = 1'b1;
        retire_w  = mem.mem_ready;
      end
      S_MEMWB: begin
        rf_we    = !reset;
        rf_wdata = mdr_q;
        retire_w = 1'b1;
      end
      S_ALUWB: begin
        rf_we    = !reset;
        retire_w = 1'b1;
      end
      S_BEQ:    retire_w = 1'b1;
      S_TRAP:   trap_w = 1'b1;
      default:  ;
    endcase
  end

  assign mem.mem_req   = mem_req_w;
  assign mem.mem_we    = mem_we_w;
  assign mem.mem_addr  = mem_addr_w;
  assign mem.mem_wdata = b_q;
  assign pc            = pc_q;
  assign retire        = retire_w;
  assign trap          = trap_w;

  always_comb begin
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    addr_d   = addr_q;
    mdr_d    = mdr_q;
    boot_d   = 1'b0;
    case (state_q)
      S_FETCH: if (xfer) begin
        ir_d     = mem.mem_rdata;
        old_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end
      S_DECODE: begin
        a_d = rs1_val;
        b_d = rs2_val;
      end
      S_MEMADR: addr_d = (a_q + (is_sw ? imm_s : imm_i)) & 32'hFFFF_FFFC;
      S_MEMRD:  if (xfer) mdr_d = mem.mem_rdata;
      S_EXECR, S_EXECI: alu_d = alu_res;
      S_BEQ:    if (a_q == b_q) pc_d = old_pc_q + imm_b;
      S_JAL: begin
        alu_d = old_pc_q + 32'd4;
        pc_d  = old_pc_q + imm_j;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      old_pc_q <= 32'd0;
      ir_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      alu_q    <= 32'd0;
      addr_q   <= 32'd0;
      mdr_q    <= 32'd0;
      boot_q   <= 1'b1;
    end else begin
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      addr_q   <= addr_d;
      mdr_q    <= mdr_d;
      boot_q   <= boot_d;
    end
  end

  // register file survives reset; x0 is never written and reads as zero
  always_ff @(posedge clk) begin
    if (rf_we && (rd != 5'd0)) rf_q[rd] <= rf_wdata;
  end

endmodule
